// File: rtl/rv32i_clint_pkg.sv
// Shared definitions for the CLINT: timer width, mtimecmp reset value and
// the per-hart interrupt vector.
package rv32i_clint_pkg;

    localparam int unsigned MTIME_W = 64;

    // All-ones keeps the timer interrupt quiet until software programs a compare value.
    localparam logic [MTIME_W-1:0] MTIMECMP_RESET = '1;

    // One hart's pending interrupt set.
    typedef struct packed {
        logic timer;
        logic software;
        logic external;
    } hart_irq_t;

endpackage

// File: rtl/rv32i_clint_hart.sv
// One hart's interrupt state: mtimecmp register, registered timer compare,
// software-pending bit and external-interrupt synchroniser / edge latch.
module rv32i_clint_hart
    import rv32i_clint_pkg::*;
#(
    parameter int unsigned EXT_EDGE = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [MTIME_W-1:0] mtime_i,
    input  logic               mtimecmp_wr_i,
    input  logic [MTIME_W-1:0] mtimecmp_din_i,
    input  logic               sw_set_i,
    input  logic               sw_clr_i,
    input  logic               ext_irq_i,
    input  logic               ext_ack_i,
    output hart_irq_t          irq_o
);

    logic [MTIME_W-1:0] cmp_q, cmp_d;
    logic               timer_q;
    logic               sw_q, sw_d;
    logic [1:0]         sync_q;
    logic               ext_pend;

    // Next-state for compare register and software bit (set beats clear).
    always_comb begin
        cmp_d = cmp_q;
        sw_d  = sw_q;
        if (mtimecmp_wr_i) cmp_d = mtimecmp_din_i;
        if (sw_set_i)      sw_d  = 1'b1;
        else if (sw_clr_i) sw_d  = 1'b0;
    end

    // Compare register, registered comparator, software bit and two-flop synchroniser.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_q   <= MTIMECMP_RESET;
            timer_q <= 1'b0;
            sw_q    <= 1'b0;
            sync_q  <= 2'b00;
        end else begin
            cmp_q   <= cmp_d;
            timer_q <= (mtime_i >= cmp_q);
            sw_q    <= sw_d;
            sync_q  <= {sync_q[0], ext_irq_i};
        end
    end

    if (EXT_EDGE != 0) begin : g_edge
        logic prev_q;
        logic pend_q, pend_d;

        // A fresh synchronised rising edge sets pending and beats a same-cycle ack.
        always_comb begin
            pend_d = pend_q;
            if (sync_q[1] && !prev_q) pend_d = 1'b1;
            else if (ext_ack_i)       pend_d = 1'b0;
        end

        // Edge-detect history and pending latch.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                prev_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                prev_q <= sync_q[1];
                pend_q <= pend_d;
            end
        end

        assign ext_pend = pend_q;
    end else begin : g_level
        // Level mode has no pending latch, so the ack has nothing to clear.
        logic unused_ack;
        assign unused_ack = ext_ack_i;
        assign ext_pend   = sync_q[1];
    end

    assign irq_o.timer    = timer_q;
    assign irq_o.software = sw_q;
    assign irq_o.external = ext_pend;

endmodule

// File: rtl/rv32i_clint.sv
// Core-local interruptor: shared 64-bit mtime with optional prescaler and
// NUM_HARTS independent timer / software / external interrupt channels.
// Optional feature macro: CLINT_PRESCALER_EN (tick every CLK_FREQ_MHZ cycles
// when defined, every cycle otherwise).
module rv32i_clint
    import rv32i_clint_pkg::*;
#(
    parameter int unsigned NUM_HARTS    = 1,
    parameter int unsigned CLK_FREQ_MHZ = 100,
    parameter int unsigned EXT_EDGE     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mtime_wr,
    input  logic [MTIME_W-1:0]   i_mtime_din,
    input  logic [NUM_HARTS-1:0] i_mtimecmp_wr,
    input  logic [MTIME_W-1:0]   i_mtimecmp_din,
    input  logic [NUM_HARTS-1:0] i_sw_set,
    input  logic [NUM_HARTS-1:0] i_sw_clr,
    input  logic [NUM_HARTS-1:0] i_ext_irq,
    input  logic [NUM_HARTS-1:0] i_ext_ack,
    output logic [MTIME_W-1:0]   o_mtime,
    output logic [NUM_HARTS-1:0] o_timer_irq,
    output logic [NUM_HARTS-1:0] o_software_irq,
    output logic [NUM_HARTS-1:0] o_external_irq
);

    logic [MTIME_W-1:0] mtime_q, mtime_d;
    logic               tick;

`ifdef CLINT_PRESCALER_EN
    localparam int unsigned PRESC_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_MHZ - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;

    assign tick = (presc_q == PRESC_MAX);

    // Prescaler wraps on tick; an mtime load restarts the tick period.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (i_mtime_wr || tick) presc_d = '0;
    end

    // Prescaler count register.
    always_ff @(posedge i_clk) begin
        if (i_rst) presc_q <= '0;
        else       presc_q <= presc_d;
    end
`else
    // Without the prescaler mtime advances every cycle.
    logic unused_clk_freq;
    assign unused_clk_freq = ^CLK_FREQ_MHZ;
    assign tick            = 1'b1;
`endif

    // A software load wins over a same-cycle increment.
    always_comb begin
        mtime_d = mtime_q;
        if (i_mtime_wr) mtime_d = i_mtime_din;
        else if (tick)  mtime_d = mtime_q + 1'b1;
    end

    // mtime register.
    always_ff @(posedge i_clk) begin
        if (i_rst) mtime_q <= '0;
        else       mtime_q <= mtime_d;
    end

    assign o_mtime = mtime_q;

    hart_irq_t hart_irq [NUM_HARTS];

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        rv32i_clint_hart #(
            .EXT_EDGE (EXT_EDGE)
        ) u_hart (
            .clk_i          (i_clk),
            .rst_i          (i_rst),
            .mtime_i        (mtime_q),
            .mtimecmp_wr_i  (i_mtimecmp_wr[h]),
            .mtimecmp_din_i (i_mtimecmp_din),
            .sw_set_i       (i_sw_set[h]),
            .sw_clr_i       (i_sw_clr[h]),
            .ext_irq_i      (i_ext_irq[h]),
            .ext_ack_i      (i_ext_ack[h]),
            .irq_o          (hart_irq[h])
        );

        assign o_timer_irq[h]    = hart_irq[h].timer;
        assign o_software_irq[h] = hart_irq[h].software;
        assign o_external_irq[h] = hart_irq[h].external;
    end

endmodule

// File: tb/tb_rv32i_clint.sv
// Self-checking bench for rv32i_clint: two harts, prescale period 4 when
// CLINT_PRESCALER_EN is defined; one edge-mode and one level-mode instance.
module tb_rv32i_clint;

`ifdef CLINT_PRESCALER_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mtime_wr;
    logic [63:0] mtime_din;
    logic [1:0]  cmp_wr;
    logic [63:0] cmp_din;
    logic [1:0]  sw_set, sw_clr, ext_irq, ext_ack;

    logic [63:0] mtime_e, mtime_l;
    logic [1:0]  timer_e, sw_e, ext_e;
    logic [1:0]  timer_l, sw_l, ext_l;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the spec says each output should be.
    logic [63:0] m_mtime;
    int          m_cnt;
    logic [63:0] m_cmp [2];
    logic [1:0]  m_timer, m_sw, m_pend;
    logic [1:0]  m_h1, m_h2, m_h3;  // ext input delayed by 1, 2, 3 edges

    always #5 clk = ~clk;

    rv32i_clint #(.NUM_HARTS(2), .CLK_FREQ_MHZ(4), .EXT_EDGE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_mtime_wr(mtime_wr), .i_mtime_din(mtime_din),
        .i_mtimecmp_wr(cmp_wr), .i_mtimecmp_din(cmp_din), .i_sw_set(sw_set),
        .i_sw_clr(sw_clr), .i_ext_irq(ext_irq), .i_ext_ack(ext_ack),
        .o_mtime(mtime_e), .o_timer_irq(timer_e), .o_software_irq(sw_e),
        .o_external_irq(ext_e)
    );

    rv32i_clint #(.NUM_HARTS(2), .CLK_FREQ_MHZ(4), .EXT_EDGE(0)) dut_lvl (
        .i_clk(clk), .i_rst(rst), .i_mtime_wr(mtime_wr), .i_mtime_din(mtime_din),
        .i_mtimecmp_wr(cmp_wr), .i_mtimecmp_din(cmp_din), .i_sw_set(sw_set),
        .i_sw_clr(sw_clr), .i_ext_irq(ext_irq), .i_ext_ack(ext_ack),
        .o_mtime(mtime_l), .o_timer_irq(timer_l), .o_software_irq(sw_l),
        .o_external_irq(ext_l)
    );

    task automatic idle();
        rst = 0; mtime_wr = 0; mtime_din = '0; cmp_wr = 0; cmp_din = '0;
        sw_set = 0; sw_clr = 0; ext_irq = 0; ext_ack = 0;
    endtask

    // Advance one clock, update the model from the spec rules, settle for sampling.
    task automatic step();
        bit tk;
        @(posedge clk);
        if (rst) begin
            m_mtime = '0; m_cnt = 0; m_cmp[0] = '1; m_cmp[1] = '1;
            m_timer = 0; m_sw = 0; m_pend = 0; m_h1 = 0; m_h2 = 0; m_h3 = 0;
        end else begin
            for (int h = 0; h < 2; h++) m_timer[h] = (m_mtime >= m_cmp[h]);
            for (int h = 0; h < 2; h++) if (cmp_wr[h]) m_cmp[h] = cmp_din;
            tk = (m_cnt == P - 1);
            if (mtime_wr) begin
                m_mtime = mtime_din; m_cnt = 0;
            end else if (tk) begin
                m_mtime = m_mtime + 64'd1; m_cnt = 0;
            end else begin
                m_cnt++;
            end
            m_sw   = sw_set | (m_sw & ~sw_clr);
            m_pend = (m_h2 & ~m_h3) | (m_pend & ~ext_ack);
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = ext_irq;
        end
        #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; mtime_wr = 1; mtime_din = 64'd123; cmp_wr = 2'b11; sw_set = 2'b11;
        ext_irq = 2'b11;
        step();
        idle();
        checks++; if (mtime_e !== 64'd0) begin errors++;
            $display("FAIL reset_mtime: got %0h expected 0", mtime_e); end
        checks++; if (timer_e !== 2'b00) begin errors++;
            $display("FAIL reset_timer: got %b expected 00", timer_e); end
        checks++; if (sw_e !== 2'b00) begin errors++;
            $display("FAIL reset_sw: got %b expected 00", sw_e); end
        checks++; if (ext_e !== 2'b00) begin errors++;
            $display("FAIL reset_ext_edge: got %b expected 00", ext_e); end
        checks++; if (ext_l !== 2'b00) begin errors++;
            $display("FAIL reset_ext_level: got %b expected 00", ext_l); end
    endtask

    task automatic test_tick();
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++; if (mtime_e !== m_mtime) begin errors++;
                $display("FAIL tick_model c%0d: got %0h expected %0h", i, mtime_e, m_mtime); end
            if (i == 4 || i == 12) begin
                checks++; if (mtime_e !== 64'(i / P)) begin errors++;
                    $display("FAIL tick_count c%0d: got %0d expected %0d", i, mtime_e, i / P);
                end
            end
        end
    endtask

    task automatic test_timer();
        int n;
        do_reset();
        cmp_wr = 2'b01; cmp_din = 64'd15;
        step();
        cmp_wr = 2'b00;
        n = 0;
        while (m_timer[0] !== 1'b1 && n < 300) begin
            step(); n++;
            checks++; if (timer_e !== m_timer) begin errors++;
                $display("FAIL timer_rise c%0d: got %b expected %b", n, timer_e, m_timer); end
        end
        checks++; if (n >= 300) begin errors++;
            $display("FAIL timer_timeout: got %0d cycles expected < 300", n); end
        checks++; if (mtime_e !== 64'd15 + 64'(P == 1)) begin errors++;
            $display("FAIL timer_rise_time: got mtime %0d expected %0d", mtime_e, 15 + (P == 1));
        end
        cmp_wr = 2'b01; cmp_din = 64'd100;
        step();
        cmp_wr = 2'b00;
        checks++; if (timer_e[0] !== 1'b1) begin errors++;
            $display("FAIL timer_hold: got %b expected 1", timer_e[0]); end
        step();
        checks++; if (timer_e[0] !== 1'b0) begin errors++;
            $display("FAIL timer_fall: got %b expected 0", timer_e[0]); end
    endtask

    task automatic test_mtime_wrap();
        int n;
        do_reset();
        mtime_wr = 1; mtime_din = '1;
        step();
        mtime_wr = 0;
        checks++; if (mtime_e !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++;
            $display("FAIL wrap_load: got %0h expected all-ones", mtime_e); end
        for (int i = 0; i < P; i++) step();
        checks++; if (mtime_e !== 64'd0) begin errors++;
            $display("FAIL wrap_zero: got %0h expected 0", mtime_e); end
        n = 0;
        while (m_cnt != P - 1 && n < 10) begin step(); n++; end
        mtime_wr = 1; mtime_din = 64'h1234;
        step();
        mtime_wr = 0;
        checks++; if (mtime_e !== 64'h1234) begin errors++;
            $display("FAIL wr_vs_tick: got %0h expected 1234", mtime_e); end
        for (int i = 0; i < P; i++) step();
        checks++; if (mtime_e !== 64'h1235) begin errors++;
            $display("FAIL wr_presc_clear: got %0h expected 1235", mtime_e); end
    endtask

    task automatic test_sw();
        do_reset();
        sw_set = 2'b11; sw_clr = 2'b01;
        step();
        checks++; if (sw_e !== 2'b11) begin errors++;
            $display("FAIL sw_set_wins: got %b expected 11", sw_e); end
        sw_set = 2'b00; sw_clr = 2'b01;
        step();
        checks++; if (sw_e !== 2'b10) begin errors++;
            $display("FAIL sw_clear: got %b expected 10", sw_e); end
        sw_clr = 2'b00;
        step();
        checks++; if (sw_e !== 2'b10) begin errors++;
            $display("FAIL sw_hold: got %b expected 10", sw_e); end
    endtask

    task automatic test_ext();
        do_reset();
        ext_irq = 2'b01;
        step(); step();
        checks++; if (ext_e !== 2'b00) begin errors++;
            $display("FAIL ext_edge_early: got %b expected 00", ext_e); end
        checks++; if (ext_l !== 2'b01) begin errors++;
            $display("FAIL ext_level_lat: got %b expected 01", ext_l); end
        step();
        checks++; if (ext_e !== 2'b01) begin errors++;
            $display("FAIL ext_edge_set: got %b expected 01", ext_e); end
        ext_ack = 2'b01;
        step();
        ext_ack = 2'b00;
        checks++; if (ext_e !== 2'b00) begin errors++;
            $display("FAIL ext_ack: got %b expected 00", ext_e); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (ext_e !== 2'b00) begin errors++;
                $display("FAIL ext_held_high c%0d: got %b expected 00", i, ext_e); end
        end
        ext_irq = 2'b00; step(); step(); step();
        ext_irq = 2'b01; step(); step(); step();
        ext_irq = 2'b00; step(); step(); step();
        checks++; if (ext_e !== 2'b01) begin errors++;
            $display("FAIL ext_latched: got %b expected 01", ext_e); end
        ext_irq = 2'b01; step(); step();
        ext_ack = 2'b01;
        step();
        ext_ack = 2'b00;
        checks++; if (ext_e !== 2'b01) begin errors++;
            $display("FAIL ext_edge_wins: got %b expected 01", ext_e); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmp_wr = 2'b11; cmp_din = 64'd0; sw_set = 2'b11; ext_irq = 2'b11;
        step();
        cmp_wr = 2'b00; sw_set = 2'b00;
        for (int i = 0; i < 5; i++) step();
        checks++; if ({timer_e, sw_e, ext_e} !== 6'b11_11_11) begin errors++;
            $display("FAIL mid_preset: got %b expected 111111", {timer_e, sw_e, ext_e}); end
        rst = 1; mtime_wr = 1; mtime_din = 64'd77; cmp_wr = 2'b11; sw_set = 2'b11;
        step();
        idle();
        checks++; if ({mtime_e, timer_e, sw_e, ext_e, ext_l} !== 72'd0) begin errors++;
            $display("FAIL mid_reset: got %0h/%b/%b/%b/%b expected all 0",
                     mtime_e, timer_e, sw_e, ext_e, ext_l); end
        step(); step();
        checks++; if (timer_e !== 2'b00) begin errors++;
            $display("FAIL mid_cmp_ones: got %b expected 00", timer_e); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            mtime_wr = ($urandom_range(0, 29) == 0);
            mtime_din = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3))
                                                    : m_mtime + 64'($urandom_range(0, 40));
            cmp_wr  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            cmp_din = m_mtime + 64'($urandom_range(0, 20));
            sw_set  = 2'($urandom) & 2'($urandom);
            sw_clr  = 2'($urandom) & 2'($urandom);
            if ($urandom_range(0, 3) == 0) ext_irq = 2'($urandom);
            ext_ack = 2'($urandom) & 2'($urandom);
            step();
            checks++; if (mtime_e !== m_mtime || mtime_l !== m_mtime) begin errors++;
                $display("FAIL rnd_mtime c%0d: got %0h/%0h expected %0h", i, mtime_e, mtime_l,
                         m_mtime); end
            checks++; if (timer_e !== m_timer || timer_l !== m_timer) begin errors++;
                $display("FAIL rnd_timer c%0d: got %b/%b expected %b", i, timer_e, timer_l,
                         m_timer); end
            checks++; if (sw_e !== m_sw || sw_l !== m_sw) begin errors++;
                $display("FAIL rnd_sw c%0d: got %b/%b expected %b", i, sw_e, sw_l, m_sw); end
            checks++; if (ext_e !== m_pend) begin errors++;
                $display("FAIL rnd_ext_edge c%0d: got %b expected %b", i, ext_e, m_pend); end
            checks++; if (ext_l !== m_h2) begin errors++;
                $display("FAIL rnd_ext_level c%0d: got %b expected %b", i, ext_l, m_h2); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_tick();
        test_timer();
        test_mtime_wrap();
        test_sw();
        test_ext();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_clint.md
RV32I_CLINT -- requirements
Module: rv32i_clint

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, number of interrupt channels (1..8).
REQ-002 SHALL have parameter CLK_FREQ_MHZ, default 100, clock cycles per mtime tick when prescaling (≥1).
REQ-003 SHALL have parameter EXT_EDGE, default 0; 0 = external interrupt level-sensitive, 1 = rising-edge latched.
REQ-004 Ports:
- i_clk, input, 1: single clock; rising edge.
- i_rst, input, 1: reset, synchronous, active-high.
- i_mtime_wr, input, 1: load mtime.
- i_mtime_din, input, 64: mtime load value.
- i_mtimecmp_wr, input, NUM_HARTS: per-hart mtimecmp load strobe.
- i_mtimecmp_din, input, 64: shared mtimecmp load value.
- i_sw_set, input, NUM_HARTS: set software-pending bit.
- i_sw_clr, input, NUM_HARTS: clear software-pending bit.
- i_ext_irq, input, NUM_HARTS: external interrupt source.
- i_ext_ack, input, NUM_HARTS: clear latched external pending (EXT_EDGE=1 only).
- o_mtime, output, 64: current mtime.
- o_timer_irq, output, NUM_HARTS: timer interrupt pending.
- o_software_irq, output, NUM_HARTS: software interrupt pending.
- o_external_irq, output, NUM_HARTS: external interrupt pending.

Function
REQ-005 Tick: prescaler counts 0..CLK_FREQ_MHZ-1; tick asserts one cycle when the count is CLK_FREQ_MHZ-1, then the count wraps to 0.
REQ-006 mtime SHALL increment by 1 on each tick; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-007 i_mtime_wr SHALL load i_mtime_din next cycle, overriding a same-cycle tick, and clear the prescaler to 0.
REQ-008 i_mtimecmp_wr[h] SHALL load i_mtimecmp_din into mtimecmp[h] next cycle; multiple bits set load all selected harts.
REQ-009 o_timer_irq[h] SHALL be registered (mtime >= mtimecmp[h]), unsigned 64-bit, using the registered values of mtime and mtimecmp[h]; the output reflects any change one cycle after the register updates.
REQ-010 o_software_irq[h]: set by i_sw_set[h], cleared by i_sw_clr[h]; simultaneous set and clear, set wins; otherwise holds.
REQ-011 EXT_EDGE=0: o_external_irq[h] SHALL be i_ext_irq[h] registered through two flops (2-cycle latency); i_ext_ack ignored.
REQ-012 EXT_EDGE=1: after the two-flop synchroniser, a 0→1 transition sets pending[h]; i_ext_ack[h] clears it; simultaneous edge and ack, set wins; a held-high input does not re-set pending after ack.
REQ-013 Harts SHALL be fully independent; no cross-hart interaction other than shared mtime and i_mtimecmp_din.

Reset
REQ-014 On i_rst SHALL clear: mtime=0, prescaler=0, mtimecmp[*]=64'hFFFF_FFFF_FFFF_FFFF, software/external pending=0, synchroniser flops=0, all outputs 0.
REQ-015 Reset SHALL override every concurrent write, set, or edge; first tick occurs CLK_FREQ_MHZ cycles after reset deasserts (prescaler enabled).

Configuration
REQ-016 Macro CLINT_PRESCALER_EN: when defined, ticks per REQ-005; when undefined, the prescaler is absent, tick is constant 1, and mtime increments every cycle (CLK_FREQ_MHZ unused).

Structure
REQ-017 Shared package rv32i_clint_pkg SHALL hold MTIME_W=64, MTIMECMP_RESET constant, and the per-hart interrupt-vector typedef.
REQ-018 Sub-module rv32i_clint_hart SHALL hold one hart's mtimecmp, comparator, software bit, and external sync/latch; instantiated NUM_HARTS times via generate.

Verification
REQ-019 Prescaler on, CLK_FREQ_MHZ=4, reset released -> o_mtime=1 after 4 cycles, =3 after 12 cycles.
REQ-020 mtimecmp[0]=15 written, mtime free-running from 0 -> o_timer_irq[0] rises on the cycle after mtime reaches 15; mtimecmp[0] rewritten to 100 -> falls one cycle after the mtimecmp register updates.
REQ-021 mtime written to 64'hFFFF_FFFF_FFFF_FFFF, prescaler off -> next cycle 0; mtime write coincident with tick -> loaded value, no increment.
REQ-022 NUM_HARTS=2, i_sw_set=2'b11 and i_sw_clr=2'b01 same cycle -> o_software_irq=2'b11; next-cycle i_sw_clr=2'b01 alone -> 2'b10.
REQ-023 EXT_EDGE=1, i_ext_irq[0] rises and is held -> o_external_irq[0]=1 after 3 cycles; i_ext_ack[0] -> 0 and stays 0 while input high; edge coincident with ack -> remains 1.
REQ-024 i_rst asserted mid-count with pending bits set -> all outputs 0 next cycle and mtimecmp reads all-ones (no timer irq).
